i2c_slave: RTL and testbench

I2C target (responder) for the FMC151 control path: it is the bus-side counterpart to `i2c_master`, answering transactions addressed to `SLAVE_ADDR`. It exposes an 8-bit register-pointer interface to a local register bank. The first written byte sets the pointer; subsequent written and read bytes access the bank with pointer auto-increment. It never drives SCL (no clock stretching) and drives SDA open-drain only.

---
 rtl/i2c_slave.sv | 163 ++++++++++++++++
 tb/tb_i2c_slave.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with an auto-incrementing 8-bit register pointer onto a local bank
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, MACK, IGNORE} state_t;
  state_t state_q, state_d;
  logic [1:0] s1_q, s2_q, flt_q, flt_d, prv_q;
  logic [1:0][CW-1:0] fc_q, fc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, tx_q, tx_d, ptr_q, ptr_d, wdata_q, wdata_d;
  logic oe_q, oe_d, rw_q, rw_d, we_q, we_d, re_q, re_d, cap_q, busy_q, busy_d;
  logic rise, fall, start, stop;
  // Bit 1 carries SCL, bit 0 carries SDA through the synchroniser and filter
  assign rise  = flt_q[1] & ~prv_q[1];
  assign fall  = ~flt_q[1] & prv_q[1];
  assign start = flt_q[1] & prv_q[1] & prv_q[0] & ~flt_q[0];
  assign stop  = flt_q[1] & prv_q[1] & ~prv_q[0] & flt_q[0];
  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  always_comb begin
    flt_d = flt_q;
    fc_d  = '0;
    for (int i = 0; i < 2; i++)
      if (s2_q[i] != flt_q[i]) begin
        if (fc_q[i] == CW'(FILTER_LEN - 1)) flt_d[i] = s2_q[i];
        else fc_d[i] = fc_q[i] + 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tx_d    = cap_q ? reg_rdata : tx_q;
    ptr_d   = (we_q | cap_q) ? ptr_q + 8'd1 : ptr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (rise) begin
      cnt_d = cnt_q + 1'b1;
      sr_d  = {sr_q[6:0], flt_q[0]};
      re_d  = (state_q == ADDR_ACK && rw_q) || (state_q == MACK && !flt_q[0]);
      if (state_q == MACK && flt_q[0]) begin
        state_d = IGNORE;
        busy_d  = 1'b0;
      end
    end else if (fall) begin
      case (state_q)
        ADDR: if (cnt_q == 4'd8) begin
          cnt_d   = '0;
          rw_d    = sr_q[0];
          state_d = (sr_q[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
          oe_d    = sr_q[7:1] == SLAVE_ADDR;
          busy_d  = sr_q[7:1] == SLAVE_ADDR;
        end
        ADDR_ACK: begin
          cnt_d   = '0;
          state_d = rw_q ? RD : PTR;
          oe_d    = rw_q & ~tx_q[7];
        end
        PTR: if (cnt_q == 4'd8) begin
          cnt_d   = '0;
          ptr_d   = sr_q;
          oe_d    = 1'b1;
          state_d = PTR_ACK;
        end
        PTR_ACK, WR_ACK: begin
          cnt_d   = '0;
          oe_d    = 1'b0;
          state_d = WR;
        end
        WR: if (cnt_q == 4'd8) begin
          cnt_d   = '0;
          we_d    = 1'b1;
          wdata_d = sr_q;
          oe_d    = 1'b1;
          state_d = WR_ACK;
        end
        RD: if (cnt_q == 4'd8) begin
          cnt_d   = '0;
          oe_d    = 1'b0;
          state_d = MACK;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
          oe_d = ~tx_q[6];
        end
        MACK: begin
          cnt_d   = '0;
          oe_d    = ~tx_q[7];
          state_d = RD;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 2'b11;
      s2_q    <= 2'b11;
      flt_q   <= 2'b11;
      prv_q   <= 2'b11;
      fc_q    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      tx_q    <= '0;
      ptr_q   <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      cap_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= {scl, sda};
      s2_q    <= s1_q;
      flt_q   <= flt_d;
      prv_q   <= flt_q;
      fc_q    <= fc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      we_q    <= we_d;
      re_q    <= re_d;
      cap_q   <= re_q;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-master bench for i2c_slave with a small register-bank model
module tb_i2c_slave;
  localparam int Q = 12;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_low = 1'b0;
  logic [7:0] reg_addr, reg_wdata, reg_rdata = 8'h00;
  logic reg_we, reg_re, busy;
  wire sda;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] we_a[$], we_v[$], re_a[$];
  logic both_seen = 1'b0, busy_seen = 1'b0, drv_seen = 1'b0;
  logic ack;
  logic [7:0] b;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_slave dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  // Bank returns 0x20 + address, one cycle after the read strobe
  always @(posedge clk) if (reg_re) reg_rdata <= 8'h20 + reg_addr;

  always @(negedge clk) begin
    if (reg_we) begin
      we_a.push_back(reg_addr);
      we_v.push_back(reg_wdata);
    end
    if (reg_re) re_a.push_back(reg_addr);
    if (reg_we && reg_re) both_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (!sda_low && sda === 1'b0) drv_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic bus_rstart();
    sda_low = 1'b0; tick(Q);
    scl = 1'b1; tick(2 * Q);
    bus_start();
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; tick(Q);
    scl = 1'b1; tick(2 * Q);
    sda_low = 1'b0; tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input int g, output logic a);
    for (int i = 7; i >= 0; i--) begin
      sda_low = ~v[i]; tick(Q);
      scl = 1'b1;
      if (i == g) begin
        tick(Q); scl = 1'b0; tick(1); scl = 1'b1; tick(Q - 1);
      end else tick(2 * Q);
      scl = 1'b0; tick(Q);
    end
    sda_low = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    a = sda; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    sda_low = 1'b0;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      tick(Q); scl = 1'b1;
      tick(Q); v = {v[6:0], sda};
      tick(Q); scl = 1'b0;
      tick(Q);
    end
    sda_low = mack; tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
    sda_low = 1'b0;
  endtask

  task automatic clear_log();
    we_a.delete(); we_v.delete(); re_a.delete();
    busy_seen = 1'b0; drv_seen = 1'b0;
  endtask

  initial begin
    tick(5);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_we", reg_we, 1'b0);
    check("rst_re", reg_re, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    tick(10);

    clear_log();
    bus_start();
    send_byte(8'hA0, -1, ack); check("wr_ack_addr", ack, 1'b0);
    check("wr_busy", busy, 1'b1);
    send_byte(8'h10, -1, ack); check("wr_ack_ptr", ack, 1'b0);
    send_byte(8'h5A, -1, ack); check("wr_ack_d0", ack, 1'b0);
    send_byte(8'hC3, -1, ack); check("wr_ack_d1", ack, 1'b0);
    bus_stop();
    check("wr_we_count", we_a.size(), 2);
    check("wr_we0_addr", we_a[0], 8'h10);
    check("wr_we0_data", we_v[0], 8'h5A);
    check("wr_we1_addr", we_a[1], 8'h11);
    check("wr_we1_data", we_v[1], 8'hC3);
    check("wr_final_ptr", reg_addr, 8'h12);
    check("wr_busy_stop", busy, 1'b0);

    clear_log();
    bus_start();
    send_byte(8'hA0, -1, ack); check("rd_ack_waddr", ack, 1'b0);
    send_byte(8'h20, -1, ack); check("rd_ack_ptr", ack, 1'b0);
    bus_rstart();
    send_byte(8'hA1, -1, ack); check("rd_ack_raddr", ack, 1'b0);
    recv_byte(1'b1, b); check("rd_byte0", b, 8'h40);
    recv_byte(1'b1, b); check("rd_byte1", b, 8'h41);
    recv_byte(1'b0, b); check("rd_byte2", b, 8'h42);
    check("rd_busy_nack", busy, 1'b0);
    bus_stop();
    check("rd_re_count", re_a.size(), 3);
    check("rd_re0", re_a[0], 8'h20);
    check("rd_re1", re_a[1], 8'h21);
    check("rd_re2", re_a[2], 8'h22);
    check("rd_final_ptr", reg_addr, 8'h23);

    clear_log();
    bus_start();
    send_byte(8'hA2, -1, ack); check("mm_nack_addr", ack, 1'b1);
    send_byte(8'h33, -1, ack); check("mm_nack_data", ack, 1'b1);
    bus_stop();
    check("mm_we_count", we_a.size(), 0);
    check("mm_re_count", re_a.size(), 0);
    check("mm_busy_seen", busy_seen, 1'b0);
    check("mm_sda_driven", drv_seen, 1'b0);

    clear_log();
    bus_start();
    send_byte(8'hA0, -1, ack);
    send_byte(8'hFF, -1, ack);
    send_byte(8'h01, -1, ack);
    send_byte(8'h02, -1, ack);
    send_byte(8'h03, -1, ack);
    bus_stop();
    check("wrap_we_count", we_a.size(), 3);
    check("wrap_we0", we_a[0], 8'hFF);
    check("wrap_we1", we_a[1], 8'h00);
    check("wrap_we2", we_a[2], 8'h01);
    check("wrap_ptr", reg_addr, 8'h02);

    clear_log();
    bus_start();
    send_byte(8'hA0, 3, ack); check("gl_ack_addr", ack, 1'b0);
    send_byte(8'h30, 5, ack); check("gl_ack_ptr", ack, 1'b0);
    send_byte(8'h77, -1, ack);
    bus_stop();
    check("gl_we_addr", we_a[0], 8'h30);
    check("gl_we_data", we_v[0], 8'h77);

    bus_start();
    send_byte(8'hA1, -1, ack); check("rs_ack", ack, 1'b0);
    check("rs_rd_drive", sda, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rs_sda_release", sda, 1'b1);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rs_busy", busy, 1'b0);
    check("rs_ptr", reg_addr, 8'h00);
    bus_rstart();
    send_byte(8'hA1, -1, ack); check("rs_ack_after", ack, 1'b0);
    recv_byte(1'b0, b); check("rs_byte", b, 8'h20);
    bus_stop();
    check("we_re_overlap", both_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
